tone_sequencer: RTL and testbench

- Upstream stage of the speaker driver.
- Walks a note table and produces a gated square-wave `tone_out`; the driver turns it into the differential GPIO pair.
- Each table step has a half-period divisor and a duration; a fixed silent gap separates notes.
- The table lives in an external synchronous ROM/EBR read through an address/data port with 1-cycle read latency.

---
 rtl/tone_pkg.sv | 28 ++
 rtl/tone_divider.sv | 66 ++++++
 rtl/tone_sequencer.sv | 141 ++++++++++++++
 tb/tb_tone_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer: FSM state encoding, default widths
// and half-period divisor constants for a 48 MHz clock.
package tone_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_RDWAIT,
      ST_PLAY,
      ST_GAP,
      ST_END
   } state_t;

   localparam int unsigned TONE_DIV_W = 16;
   localparam int unsigned TONE_DUR_W = 24;
   localparam int unsigned CLK_HZ     = 48_000_000;

   // Divisor value that makes each tone level last (div+1) cycles at CLK_HZ.
   function automatic int unsigned half_div(input int unsigned hz);
      return CLK_HZ / (2 * hz) - 1;
   endfunction

   localparam int unsigned NOTE_A4 = half_div(440);  // 54544
   localparam int unsigned NOTE_C5 = half_div(523);
   localparam int unsigned NOTE_E5 = half_div(659);
   localparam int unsigned NOTE_A5 = half_div(880);

endpackage

// File: rtl/tone_divider.sv
// Reloadable half-period counter plus toggle flop; each tone level lasts div+1 cycles.
// With TONE_SEQ_DIFF_EN defined it also registers the differential pair spk_p/spk_n.
module tone_divider
   import tone_pkg::*;
#(
   parameter int unsigned DIV_W = TONE_DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic             tone
`ifdef TONE_SEQ_DIFF_EN
   ,
   input  logic             drive,
   output logic             spk_p,
   output logic             spk_n
`endif
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_d;
   logic             tone_d;

   // load restarts the waveform low; it wins over enable.
   always_comb begin
      cnt_d  = cnt;
      tone_d = tone;
      if (load) begin
         cnt_d  = div;
         tone_d = 1'b0;
      end else if (enable) begin
         if (cnt == '0) begin
            cnt_d  = div;
            tone_d = ~tone;
         end else begin
            cnt_d = cnt - DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tone <= 1'b0;
      end else begin
         cnt  <= cnt_d;
         tone <= tone_d;
      end
   end

`ifdef TONE_SEQ_DIFF_EN
   // Both legs low when not driving so no DC sits across the speaker.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spk_p <= 1'b0;
         spk_n <= 1'b0;
      end else begin
         spk_p <= drive & tone_d;
         spk_n <= drive & ~tone_d;
      end
   end
`endif

endmodule

// File: rtl/tone_sequencer.sv
// Walks a note table in an external 1-cycle-latency ROM and emits a gated square wave.
// Optional macro TONE_SEQ_DIFF_EN adds registered differential outputs spk_p/spk_n.
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int unsigned ADDR_W  = 3,
   parameter int unsigned DIV_W   = TONE_DIV_W,
   parameter int unsigned DUR_W   = TONE_DUR_W,
   parameter int unsigned GAP_CYC = 4800
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DIV_W-1:0]  rd_div,
   input  logic [DUR_W-1:0]  rd_dur,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] step_idx,
   output logic              tone_out
`ifdef TONE_SEQ_DIFF_EN
   ,
   output logic              spk_p,
   output logic              spk_n
`endif
);

   localparam int unsigned      GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

   state_t             state;
   state_t             next_state;
   logic [DIV_W-1:0]   div_q;
   logic [DIV_W-1:0]   div_in;
   logic [DUR_W-1:0]   dur_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic               played;
   logic               finish;
   logic               last_step;
   logic               tone_load;
   logic               tone_en;

   assign last_step = &rd_addr;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      finish     = 1'b0;
      div_in     = div_q;
      case (state)
         ST_IDLE:   if (start) next_state = ST_FETCH;
         ST_FETCH:  next_state = ST_RDWAIT;
         ST_RDWAIT: begin
            div_in     = rd_div;
            next_state = (rd_dur == '0) ? ST_END : ST_PLAY;
         end
         ST_PLAY: begin
            if (dur_cnt == DUR_W'(1)) begin
               if (GAP_CYC != 0) next_state = ST_GAP;
               else              next_state = last_step ? ST_END : ST_FETCH;
            end
         end
         ST_GAP: if (gap_cnt == '0) next_state = last_step ? ST_END : ST_FETCH;
         ST_END: begin
            // A table that never played a note cannot loop, avoiding a zero-length spin.
            if (loop_en && played) begin
               next_state = ST_FETCH;
            end else begin
               finish     = 1'b1;
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
      if (stop) begin
         next_state = ST_IDLE;
         finish     = 1'b0;
      end
   end

   assign tone_load = (state != ST_PLAY) || (next_state != ST_PLAY);
   assign tone_en   = !tone_load && (div_q != '0);
   assign done      = finish;
   assign busy      = (state != ST_IDLE) && !finish;

   // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         rd_addr  <= '0;
         step_idx <= '0;
         div_q    <= '0;
         dur_cnt  <= '0;
         gap_cnt  <= '0;
         played   <= 1'b0;
      end else begin
         state <= next_state;

         if (next_state == ST_IDLE || (state == ST_END && next_state == ST_FETCH))
            rd_addr <= '0;
         else if ((state == ST_PLAY || state == ST_GAP) && next_state == ST_FETCH)
            rd_addr <= rd_addr + ADDR_W'(1);

         if (state == ST_IDLE && next_state == ST_FETCH) played <= 1'b0;

         if (state == ST_RDWAIT) begin
            div_q   <= rd_div;
            dur_cnt <= rd_dur;
            if (next_state == ST_PLAY) begin
               step_idx <= rd_addr;
               played   <= 1'b1;
            end
         end else if (state == ST_PLAY && dur_cnt != '0) begin
            dur_cnt <= dur_cnt - DUR_W'(1);
         end

         if (state == ST_PLAY)                      gap_cnt <= GAP_LOAD;
         else if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

   tone_divider #(
      .DIV_W (DIV_W)
   ) u_divider (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (tone_load),
      .enable (tone_en),
      .div    (div_in),
      .tone   (tone_out)
`ifdef TONE_SEQ_DIFF_EN
      ,
      .drive  ((next_state == ST_PLAY) && (div_in != '0)),
      .spk_p  (spk_p),
      .spk_n  (spk_n)
`endif
   );

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: a per-cycle reference trace is built from
// the note table by walking it step by step, then compared against the DUT.
module tb_tone_sequencer;

   localparam int ADDR_W = 3;
   localparam int DIV_W  = 16;
   localparam int DUR_W  = 24;
   localparam int GAP    = 2;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              loop_en = 1'b0;
   logic [ADDR_W-1:0] rd_addr;
   logic [DIV_W-1:0]  rd_div = '0;
   logic [DUR_W-1:0]  rd_dur = '0;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] step_idx;
   logic              tone_out;
`ifdef TONE_SEQ_DIFF_EN
   logic              spk_p;
   logic              spk_n;
`endif

   logic [DIV_W-1:0] tbl_div [DEPTH];
   logic [DUR_W-1:0] tbl_dur [DEPTH];

   typedef struct {
      bit busy;
      bit done;
      bit tone;
      bit chk_step;
      int step;
      bit chk_addr;
      int addr;
      bit is_end;
   } exp_t;

   exp_t exp_q[$];
   bit   seen_tone[$];
   int   checks = 0;
   int   errors = 0;

   tone_sequencer #(
      .ADDR_W  (ADDR_W),
      .DIV_W   (DIV_W),
      .DUR_W   (DUR_W),
      .GAP_CYC (GAP)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .loop_en  (loop_en),
      .rd_addr  (rd_addr),
      .rd_div   (rd_div),
      .rd_dur   (rd_dur),
      .busy     (busy),
      .done     (done),
      .step_idx (step_idx),
      .tone_out (tone_out)
`ifdef TONE_SEQ_DIFF_EN
      ,
      .spk_p    (spk_p),
      .spk_n    (spk_n)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous table ROM, one cycle of read latency.
   always @(posedge clk) begin
      rd_div <= tbl_div[rd_addr];
      rd_dur <= tbl_dur[rd_addr];
   end

   function automatic void push(bit b, bit d, bit t, bit cs, int s, bit ca, int a, bit e);
      exp_t x;
      x.busy = b; x.done = d; x.tone = t; x.chk_step = cs; x.step = s;
      x.chk_addr = ca; x.addr = a; x.is_end = e;
      exp_q.push_back(x);
   endfunction

   // Expected trace, one entry per cycle starting the cycle after start is sampled.
   // The END of pass p (0-based) loops when p < passes-1 and a note has played.
   task automatic build_model(input int passes);
      bit played = 0;
      bit fin = 0;
      int ends = 0;
      exp_q.delete();
      while (!fin) begin
         for (int s = 0; s < DEPTH; s++) begin
            push(1, 0, 0, 0, 0, 1, s, 0);
            push(1, 0, 0, 0, 0, 0, 0, 0);
            if (tbl_dur[s] == '0) break;
            played = 1;
            for (int k = 0; k < int'(tbl_dur[s]); k++)
               push(1, 0, (tbl_div[s] == '0) ? 1'b0 : bit'((k / (int'(tbl_div[s]) + 1)) % 2),
                    1, s, 0, 0, 0);
            for (int g = 0; g < GAP; g++) push(1, 0, 0, 0, 0, 0, 0, 0);
         end
         if (ends < passes - 1 && played) begin
            push(1, 0, 0, 0, 0, 0, 0, 1);
         end else begin
            push(0, 1, 0, 0, 0, 0, 0, 1);
            fin = 1;
         end
         ends++;
      end
   endtask

   task automatic run_seq(input string tag, input int passes, input bit noise_start);
      int ends = 0;
      seen_tone.delete();
      build_model(passes);
      @(negedge clk);
      start   = 1'b1;
      loop_en = 1'($urandom);
      @(posedge clk); #1;
      start = 1'b0;
      foreach (exp_q[i]) begin
         exp_t e = exp_q[i];
         loop_en = e.is_end ? (ends < passes - 1) : 1'($urandom);
         if (noise_start) start = 1'($urandom);
         #0;
         checks++;
         if (busy !== e.busy) begin
            errors++;
            $display("FAIL %s busy cyc %0d got %b want %b", tag, i, busy, e.busy);
         end
         checks++;
         if (done !== e.done) begin
            errors++;
            $display("FAIL %s done cyc %0d got %b want %b", tag, i, done, e.done);
         end
         checks++;
         if (tone_out !== e.tone) begin
            errors++;
            $display("FAIL %s tone_out cyc %0d got %b want %b", tag, i, tone_out, e.tone);
         end
         if (e.chk_step) begin
            checks++;
            if (step_idx !== ADDR_W'(e.step)) begin
               errors++;
               $display("FAIL %s step_idx cyc %0d got %0d want %0d", tag, i, step_idx, e.step);
            end
         end
         if (e.chk_addr) begin
            checks++;
            if (rd_addr !== ADDR_W'(e.addr)) begin
               errors++;
               $display("FAIL %s rd_addr cyc %0d got %0d want %0d", tag, i, rd_addr, e.addr);
            end
         end
         seen_tone.push_back(tone_out);
         if (e.is_end) ends++;
         @(posedge clk); #1;
      end
      start   = 1'b0;
      loop_en = 1'b0;
      #0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || rd_addr !== '0) begin
         errors++;
         $display("FAIL %s idle_after busy/done/rd_addr got %b/%b/%0d want 0/0/0",
                  tag, busy, done, rd_addr);
      end
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if ({busy, done, tone_out, rd_addr, step_idx} !== '0) begin
         errors++;
         $display("FAIL %s outputs busy=%b done=%b tone=%b rd_addr=%0d step_idx=%0d want all 0",
                  tag, busy, done, tone_out, rd_addr, step_idx);
      end
   endtask

   task automatic load_basic_table();
      for (int i = 0; i < DEPTH; i++) begin
         tbl_div[i] = DIV_W'($urandom_range(0, 5));
         tbl_dur[i] = DUR_W'($urandom_range(1, 9));
      end
      tbl_div[0] = 3; tbl_dur[0] = 16;
      tbl_div[1] = 0; tbl_dur[1] = 8;
      tbl_dur[2] = 0;
   endtask

   // Starts step0 (div=1, dur=20) and returns in PLAY cycle k=3, where tone_out is high.
   task automatic enter_play_high(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         tbl_div[i] = 1;
         tbl_dur[i] = 0;
      end
      tbl_dur[0] = 20;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      checks++;
      if (tone_out !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s pre tone/busy got %b/%b want 1/1", tag, tone_out, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check_all_zero("reset_release");
   endtask

   task automatic test_basic();
      logic [15:0] pat = '0;
      load_basic_table();
      run_seq("basic", 1, 0);
      for (int i = 2; i < 18; i++) pat = {pat[14:0], logic'(seen_tone[i])};
      checks++;
      if (pat !== 16'b0000111100001111) begin
         errors++;
         $display("FAIL basic tone_pattern got %b want 0000111100001111", pat);
      end
   endtask

   task automatic test_loop();
      load_basic_table();
      run_seq("loop", 3, 0);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < DEPTH; i++) begin
         tbl_div[i] = DIV_W'($urandom_range(0, 4));
         tbl_dur[i] = DUR_W'($urandom_range(1, 12));
      end
      run_seq("wrap", 1, 1);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            tbl_div[i] = DIV_W'($urandom_range(0, 6));
            tbl_dur[i] = ($urandom_range(0, 4) == 0) ? '0 : DUR_W'($urandom_range(1, 10));
         end
         run_seq("random", $urandom_range(1, 3), 1);
      end
   endtask

   task automatic test_stop();
      enter_play_high("stop");
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || tone_out !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL stop after busy/tone/done got %b/%b/%b want 0/0/0", busy, tone_out, done);
      end
      repeat (4) begin
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop later done/busy got %b/%b want 0/0", done, busy);
         end
      end
   endtask

   task automatic test_async_reset();
      enter_play_high("async_rst");
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check_all_zero("async_rst_release");
   endtask

   task automatic test_start_stop();
      @(negedge clk); start = 1'b1; stop = 1'b1;
      @(posedge clk); #1; start = 1'b0; stop = 1'b0;
      repeat (3) begin
         checks++;
         if (busy !== 1'b0 || rd_addr !== '0) begin
            errors++;
            $display("FAIL start_stop busy/rd_addr got %b/%0d want 0/0", busy, rd_addr);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_guard();
      load_basic_table();
      tbl_dur[0] = 0;
      run_seq("guard", 5, 0);
      repeat (4) begin
         @(posedge clk); #1;
         checks++;
         if (busy !== 1'b0 || done !== 1'b0 || rd_addr !== '0) begin
            errors++;
            $display("FAIL guard refetch busy/done/rd_addr got %b/%b/%0d want 0/0/0",
                     busy, done, rd_addr);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         tbl_div[i] = '0;
         tbl_dur[i] = '0;
      end
      test_reset();
      test_basic();
      test_loop();
      test_wrap();
      test_random();
      test_stop();
      test_async_reset();
      test_start_stop();
      test_guard();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
